// File: rtl/song_tutor_pkg.sv
// song_tutor_pkg: shared definitions for the piano-lesson sequencer.
//   - key codes (NOTE_NONE means no key is down)
//   - led_of(): key code -> one-hot LED pattern (C4 on bit 0 ... C5 on bit 7)
//   - lesson FSM state encoding
package song_tutor_pkg;

    localparam int NOTE_W  = 4;
    localparam int LED_MAX = 8;

    localparam logic [NOTE_W-1:0] NOTE_NONE = 4'd0;
    localparam logic [NOTE_W-1:0] NOTE_C4   = 4'd1;
    localparam logic [NOTE_W-1:0] NOTE_D    = 4'd2;
    localparam logic [NOTE_W-1:0] NOTE_E    = 4'd3;
    localparam logic [NOTE_W-1:0] NOTE_F    = 4'd4;
    localparam logic [NOTE_W-1:0] NOTE_G    = 4'd5;
    localparam logic [NOTE_W-1:0] NOTE_A    = 4'd6;
    localparam logic [NOTE_W-1:0] NOTE_B    = 4'd7;
    localparam logic [NOTE_W-1:0] NOTE_C5   = 4'd8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXPECT,
        S_HOLD,
        S_WRONG,
        S_DONE
    } state_e;

    // Unknown codes and NONE light nothing.
    function automatic logic [LED_MAX-1:0] led_of(input logic [NOTE_W-1:0] code);
        logic [LED_MAX-1:0] v;
        v = '0;
        if (code != NOTE_NONE && code <= NOTE_C5)
            v = LED_MAX'(1) << (code - 4'd1);
        return v;
    endfunction

endpackage

// File: rtl/song_tutor_if.sv
// song_tutor_if: lesson-side bus of the tutor.
//   master drives MODE, SONG_SEL, note; slave (the tutor) drives
//   Led, progress, err_count, wrong, done, stuck.
interface song_tutor_if #(
    parameter int LED_W = 8,
    parameter int SEL_W = 2,
    parameter int PTR_W = 7,
    parameter int ERR_W = 8
);
    import song_tutor_pkg::*;

    logic                MODE;
    logic [SEL_W-1:0]    SONG_SEL;
    logic [NOTE_W-1:0]   note;
    logic [LED_W-1:0]    Led;
    logic [PTR_W-1:0]    progress;
    logic [ERR_W-1:0]    err_count;
    logic                wrong;
    logic                done;
    logic                stuck;

    modport master (
        output MODE, SONG_SEL, note,
        input  Led, progress, err_count, wrong, done, stuck
    );

    modport slave (
        input  MODE, SONG_SEL, note,
        output Led, progress, err_count, wrong, done, stuck
    );

endinterface

// File: rtl/song_tutor_rom.sv
// song_tutor_rom: combinational song table.
//   sel  - song index
//   idx  - note position within the song
//   code - key code at that position, NOTE_NONE past the end of the song
//   Songs: 0 = E E F, 1 = C4 D E F G A B C5, 2 = empty, 3 = G E D C4.
module song_tutor_rom
    import song_tutor_pkg::*;
#(
    parameter int NUM_SONG = 4,
    parameter int MAX_LEN  = 64,
    parameter int SEL_W    = 2,
    parameter int PTR_W    = 7
) (
    input  logic [SEL_W-1:0]  sel,
    input  logic [PTR_W-1:0]  idx,
    output logic [NOTE_W-1:0] code
);

    always_comb begin
        code = NOTE_NONE;
        if (int'(sel) < NUM_SONG && int'(idx) < MAX_LEN) begin
            case (int'(sel))
                0: case (int'(idx))
                       0, 1:    code = NOTE_E;
                       2:       code = NOTE_F;
                       default: code = NOTE_NONE;
                   endcase
                // ascending scale: position n holds code n+1
                1: if (int'(idx) < 8) code = NOTE_W'(int'(idx) + 1);
                3: case (int'(idx))
                       0:       code = NOTE_G;
                       1:       code = NOTE_E;
                       2:       code = NOTE_D;
                       3:       code = NOTE_C4;
                       default: code = NOTE_NONE;
                   endcase
                default: code = NOTE_NONE;
            endcase
        end
    end

endmodule

// File: rtl/song_tutor.sv
// song_tutor: piano-lesson sequencer.
//   CLK, RESET_N (synchronous, active low)
//   bus.slave: MODE (1 = free play), SONG_SEL, note in;
//              Led, progress, err_count, wrong, done, stuck out.
// Steps through the selected song, advancing on press-then-release of the
// expected key. All outputs are registered; Led follows the state with one
// cycle of lag.
module song_tutor
    import song_tutor_pkg::*;
#(
    parameter int LED_W    = 8,
    parameter int NUM_SONG = 4,
    parameter int MAX_LEN  = 64,
    parameter int ERR_W    = 8,
    parameter int TIMEOUT  = 50_000_000
) (
    input  logic         CLK,
    input  logic         RESET_N,
    song_tutor_if.slave  bus
);

    localparam int SEL_W = (NUM_SONG > 1) ? $clog2(NUM_SONG) : 1;
    localparam int PTR_W = $clog2(MAX_LEN + 1);
    localparam int IDL_W = $clog2(TIMEOUT + 1);
    localparam logic [PTR_W-1:0] LEN_MAX = PTR_W'(MAX_LEN);
    localparam logic [IDL_W-1:0] IDL_MAX = IDL_W'(TIMEOUT);

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [PTR_W-1:0]  prog_q, prog_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [IDL_W-1:0]  idle_q, idle_d;
    logic [LED_W-1:0]  led_q, led_d;
    logic              wrong_q, wrong_d;
    logic              done_q, done_d;
    logic              stuck_q, stuck_d;

    // In IDLE the current-note ROM port peeks at the first note of the
    // requested song so an empty song can go straight to DONE.
    logic [SEL_W-1:0]  rom_sel;
    logic [PTR_W-1:0]  rom_idx;
    logic [PTR_W-1:0]  prog_inc;
    logic [NOTE_W-1:0] exp_note;
    logic [NOTE_W-1:0] nxt_note;

    assign rom_sel  = (state_q == S_IDLE) ? bus.SONG_SEL : sel_q;
    assign rom_idx  = (state_q == S_IDLE) ? '0 : prog_q;
    assign prog_inc = prog_q + 1'b1;

    song_tutor_rom #(.NUM_SONG(NUM_SONG), .MAX_LEN(MAX_LEN), .SEL_W(SEL_W), .PTR_W(PTR_W))
        u_rom_cur (.sel(rom_sel), .idx(rom_idx), .code(exp_note));

    // Note after the current one, used to detect song end on release.
    song_tutor_rom #(.NUM_SONG(NUM_SONG), .MAX_LEN(MAX_LEN), .SEL_W(SEL_W), .PTR_W(PTR_W))
        u_rom_nxt (.sel(sel_q), .idx(prog_inc), .code(nxt_note));

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        prog_d  = prog_q;
        err_d   = err_q;
        idle_d  = '0;
        wrong_d = 1'b0;
        done_d  = 1'b0;
        stuck_d = 1'b0;

        case (state_q)
            S_EXPECT, S_HOLD, S_WRONG: led_d = LED_W'(led_of(exp_note));
            S_DONE:                    led_d = '1;
            default:                   led_d = '0;
        endcase

        if (bus.MODE) begin
            state_d = S_IDLE;
            led_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: if (bus.note == NOTE_NONE) begin
                    sel_d  = bus.SONG_SEL;
                    prog_d = '0;
                    err_d  = '0;
                    if (exp_note == NOTE_NONE) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_EXPECT;
                    end
                end
                S_EXPECT: begin
                    if (bus.note == exp_note) begin
                        state_d = S_HOLD;
                    end else if (bus.note != NOTE_NONE) begin
                        state_d = S_WRONG;
                        wrong_d = 1'b1;
                        if (err_q != '1) err_d = err_q + 1'b1;
                    end else begin
                        idle_d  = (idle_q == '1) ? idle_q : idle_q + 1'b1;
                        stuck_d = (idle_d >= IDL_MAX);
                    end
                end
                S_HOLD: if (bus.note == NOTE_NONE) begin
                    prog_d = prog_inc;
                    if (prog_inc == LEN_MAX || nxt_note == NOTE_NONE) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_EXPECT;
                    end
                end
                S_WRONG: if (bus.note == NOTE_NONE) state_d = S_EXPECT;
                S_DONE:  if (bus.SONG_SEL != sel_q) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            prog_q  <= '0;
            err_q   <= '0;
            idle_q  <= '0;
            led_q   <= '0;
            wrong_q <= 1'b0;
            done_q  <= 1'b0;
            stuck_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            prog_q  <= prog_d;
            err_q   <= err_d;
            idle_q  <= idle_d;
            led_q   <= led_d;
            wrong_q <= wrong_d;
            done_q  <= done_d;
            stuck_q <= stuck_d;
        end
    end

    assign bus.Led       = led_q;
    assign bus.progress  = prog_q;
    assign bus.err_count = err_q;
    assign bus.wrong     = wrong_q;
    assign bus.done      = done_q;
    assign bus.stuck     = stuck_q;

endmodule

// File: tb/tb_song_tutor.sv
// tb_song_tutor: directed lesson scenarios followed by random key traffic,
// every cycle compared against a song-table reference model.
module tb_song_tutor;
    import song_tutor_pkg::*;

    localparam int LED_W    = 8;
    localparam int NUM_SONG = 4;
    localparam int MAX_LEN  = 8;
    localparam int ERR_W    = 2;
    localparam int TIMEOUT  = 10;
    localparam int SEL_W    = 2;
    localparam int PTR_W    = 4;
    localparam int ERR_SAT  = (1 << ERR_W) - 1;
    localparam int LED_ALL  = (1 << LED_W) - 1;

    // model phases
    localparam int P_OFF = 0, P_WAIT = 1, P_KEY = 2, P_BAD = 3, P_FIN = 4;

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    always #5 CLK = ~CLK;

    song_tutor_if #(.LED_W(LED_W), .SEL_W(SEL_W), .PTR_W(PTR_W), .ERR_W(ERR_W)) bus();

    song_tutor #(.LED_W(LED_W), .NUM_SONG(NUM_SONG), .MAX_LEN(MAX_LEN),
                 .ERR_W(ERR_W), .TIMEOUT(TIMEOUT))
        dut (.CLK(CLK), .RESET_N(RESET_N), .bus(bus.slave));

    // songs as note lists, 0 terminates
    int songs [4][8] = '{'{3, 3, 4, 0, 0, 0, 0, 0},
                         '{1, 2, 3, 4, 5, 6, 7, 8},
                         '{0, 0, 0, 0, 0, 0, 0, 0},
                         '{5, 3, 2, 1, 0, 0, 0, 0}};

    int total = 0;
    int bad   = 0;

    int m_ph = P_OFF, m_sel = 0, m_prog = 0, m_err = 0, m_idle = 0;
    int m_led = 0, m_wrong = 0, m_done = 0, m_stuck = 0;

    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int expn(input int s, input int p);
        if (p >= MAX_LEN) return 0;
        return songs[s][p];
    endfunction

    function automatic int ledv(input int c);
        return (c >= 1 && c <= 8) ? (1 << (c - 1)) : 0;
    endfunction

    task automatic model(input logic rst, input logic md, input int sl, input int nt);
        int e;
        if (!rst) begin
            m_ph = P_OFF; m_led = 0; m_prog = 0; m_err = 0;
            m_wrong = 0; m_done = 0; m_stuck = 0; m_idle = 0;
            return;
        end
        m_wrong = 0;
        m_done  = 0;
        if (md) begin
            m_ph = P_OFF; m_led = 0; m_stuck = 0; m_idle = 0;
            return;
        end
        e = expn(m_sel, m_prog);
        m_led = (m_ph == P_OFF) ? 0 : (m_ph == P_FIN) ? LED_ALL : ledv(e);
        case (m_ph)
            P_OFF: if (nt == 0) begin
                m_sel = sl; m_prog = 0; m_err = 0;
                if (expn(sl, 0) == 0) begin m_ph = P_FIN; m_done = 1; end
                else m_ph = P_WAIT;
            end
            P_WAIT: begin
                if (nt == e) begin
                    m_ph = P_KEY; m_idle = 0; m_stuck = 0;
                end else if (nt != 0) begin
                    m_ph = P_BAD; m_wrong = 1; m_idle = 0; m_stuck = 0;
                    if (m_err < ERR_SAT) m_err++;
                end else begin
                    m_idle++;
                    m_stuck = (m_idle >= TIMEOUT) ? 1 : 0;
                end
            end
            P_KEY: if (nt == 0) begin
                m_prog++;
                if (m_prog == MAX_LEN || expn(m_sel, m_prog) == 0) begin
                    m_ph = P_FIN; m_done = 1;
                end else m_ph = P_WAIT;
            end
            P_BAD: if (nt == 0) m_ph = P_WAIT;
            P_FIN: if (sl != m_sel) m_ph = P_OFF;
            default: m_ph = P_OFF;
        endcase
    endtask

    // one clock: drive, step the model at the edge, compare just after it
    task automatic tick(input logic rst, input logic md, input int sl, input int nt);
        RESET_N      = rst;
        bus.MODE     = md;
        bus.SONG_SEL = SEL_W'(sl);
        bus.note     = NOTE_W'(nt);
        @(posedge CLK);
        model(rst, md, sl, nt);
        #1;
        chk("led",   32'(bus.Led),       m_led);
        chk("prog",  32'(bus.progress),  m_prog);
        chk("err",   32'(bus.err_count), m_err);
        chk("wrong", 32'(bus.wrong),     m_wrong);
        chk("done",  32'(bus.done),      m_done);
        chk("stuck", 32'(bus.stuck),     m_stuck);
    endtask

    task automatic press(input int sl, input int nt);
        tick(1'b1, 1'b0, sl, nt);
        tick(1'b1, 1'b0, sl, 0);
    endtask

    initial begin
        int w;
        int sl, nt, md, rs;

        // 1: reset, play one note, reset mid-song, restart
        tick(1'b0, 1'b0, 0, 0);
        tick(1'b0, 1'b0, 0, 0);
        tick(1'b1, 1'b0, 0, 0);
        press(0, 3);
        chk("t1_prog_mid", 32'(bus.progress), 1);
        tick(1'b0, 1'b0, 0, 3);
        tick(1'b0, 1'b0, 0, 3);
        chk("t1_rst_led",  32'(bus.Led), 0);
        chk("t1_rst_prog", 32'(bus.progress), 0);
        chk("t1_rst_flags", 32'({bus.wrong, bus.done, bus.stuck}), 0);
        tick(1'b1, 1'b0, 0, 0);
        chk("t1_prog0", 32'(bus.progress), 0);
        tick(1'b1, 1'b0, 0, 0);
        chk("t1_led_e", 32'(bus.Led), 8'h04);

        // 2: song 0 = E E F
        press(0, 3);
        chk("t2_prog1", 32'(bus.progress), 1);
        press(0, 3);
        chk("t2_prog2", 32'(bus.progress), 2);
        press(0, 4);
        chk("t2_done",  32'(bus.done), 1);
        chk("t2_prog3", 32'(bus.progress), 3);
        tick(1'b1, 1'b0, 0, 0);
        chk("t2_done_pulse", 32'(bus.done), 0);
        chk("t2_led_all", 32'(bus.Led), 8'hFF);
        chk("t2_err0", 32'(bus.err_count), 0);

        // 3: wrong key, ignored key while held
        tick(1'b1, 1'b0, 1, 0);
        tick(1'b1, 1'b0, 0, 0);
        tick(1'b1, 1'b0, 0, 5);
        chk("t3_wrong", 32'(bus.wrong), 1);
        chk("t3_err1",  32'(bus.err_count), 1);
        chk("t3_prog0", 32'(bus.progress), 0);
        tick(1'b1, 1'b0, 0, 5);
        chk("t3_wrong_pulse", 32'(bus.wrong), 0);
        tick(1'b1, 1'b0, 0, 3);
        tick(1'b1, 1'b0, 0, 0);
        chk("t3_ignored", 32'(bus.progress), 0);
        press(0, 3);
        chk("t3_prog1", 32'(bus.progress), 1);

        // 4: saturation of the 2-bit error counter
        w = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b0, 0, 5);
            w += int'(bus.wrong);
            tick(1'b1, 1'b0, 0, 0);
            w += int'(bus.wrong);
        end
        chk("t4_wcnt", 32'(w), 5);
        chk("t4_sat",  32'(bus.err_count), 3);

        // 5: free-play override at progress 2
        press(0, 3);
        chk("t5_prog2", 32'(bus.progress), 2);
        tick(1'b1, 1'b1, 0, 0);
        chk("t5_led0",  32'(bus.Led), 0);
        chk("t5_hold",  32'(bus.progress), 2);
        tick(1'b1, 1'b0, 0, 3);
        chk("t5_held",  32'(bus.progress), 2);
        tick(1'b1, 1'b0, 0, 0);
        chk("t5_clr",   32'(bus.progress), 0);
        chk("t5_errclr", 32'(bus.err_count), 0);

        // 6: idle timeout
        for (int i = 0; i < TIMEOUT - 1; i++) tick(1'b1, 1'b0, 0, 0);
        chk("t6_not_yet", 32'(bus.stuck), 0);
        tick(1'b1, 1'b0, 0, 0);
        chk("t6_stuck", 32'(bus.stuck), 1);
        tick(1'b1, 1'b0, 0, 3);
        chk("t6_clear", 32'(bus.stuck), 0);
        tick(1'b1, 1'b0, 0, 0);

        // 7: empty song, then a full MAX_LEN song
        tick(1'b1, 1'b1, 0, 0);
        tick(1'b1, 1'b0, 2, 0);
        chk("t7_empty_done", 32'(bus.done), 1);
        tick(1'b1, 1'b0, 1, 0);
        tick(1'b1, 1'b0, 1, 0);
        for (int k = 1; k <= 8; k++) press(1, k);
        chk("t7_full_done", 32'(bus.done), 1);
        chk("t7_full_prog", 32'(bus.progress), MAX_LEN);

        // random traffic
        sl = 1; nt = 0;
        for (int i = 0; i < 3000; i++) begin
            rs = ($urandom_range(199) == 0) ? 0 : 1;
            md = ($urandom_range(49) == 0) ? 1 : 0;
            if ($urandom_range(39) == 0) sl = $urandom_range(NUM_SONG - 1);
            if ($urandom_range(9) >= 4) begin
                case ($urandom_range(9))
                    0, 1, 2, 3, 4: nt = 0;
                    5, 6, 7:       nt = expn(m_sel, m_prog);
                    default:       nt = $urandom_range(8);
                endcase
            end
            tick(rs[0], md[0], sl, nt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
